// File: rtl/timer_controller_pkg.sv
// Shared encodings for the interval timer controller and its prescaler.
package timer_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Mod-PRESCALE phase counter; tick is high combinationally on the last phase while enabled.
module timer_prescaler
    import timer_controller_pkg::*;
#(
    parameter int PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
        end else if (clear) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + PW'(1);
        end
    end

    assign tick = enable && (phase == LAST);

endmodule

// File: rtl/timer_controller.sv
// Programmable interval timer: IDLE/RUN/HOLD sequencing, reload/count registers and sticky irq.
//   state | meaning
//   IDLE  | stopped, prescaler cleared, Load also sets count
//   RUN   | prescaler running, count decrements on each tick
//   HOLD  | paused, count and prescaler phase frozen
module timer_controller
    import timer_controller_pkg::*;
#(
    parameter int PRESCALE = 16,
    parameter int WIDTH    = 16
) (
    input  logic             i_CLK,
    input  logic             i_RESET_n,
    input  logic             i_Load,
    input  logic [WIDTH-1:0] i_Load_Value,
    input  logic             i_Mode,
    input  logic             i_Start,
    input  logic             i_Stop,
    input  logic             i_Irq_Ack,
    output logic             o_Busy,
    output logic             o_Expired,
    output logic             o_Irq,
    output logic             o_Overrun,
    output logic [WIDTH-1:0] o_Count
);

    state_t           state, state_next;
    logic [WIDTH-1:0] count, count_next;
    logic [WIDTH-1:0] reload, reload_next;
    logic             mode, mode_next;
    logic             tick;
    logic             expiry;

    timer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk    (i_CLK),
        .rst_n  (i_RESET_n),
        .clear  (state == IDLE),
        .enable (state == RUN),
        .tick   (tick)
    );

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            state  <= IDLE;
            count  <= '0;
            reload <= '0;
            mode   <= MODE_ONESHOT;
        end else begin
            state  <= state_next;
            count  <= count_next;
            reload <= reload_next;
            mode   <= mode_next;
        end
    end

    always_comb begin
        state_next  = state;
        count_next  = count;
        reload_next = i_Load ? i_Load_Value : reload;
        mode_next   = mode;
        expiry      = 1'b0;
        case (state)
            IDLE: begin
                if (i_Load) count_next = i_Load_Value;
                if (i_Start && !i_Stop) begin
                    state_next = RUN;
                    count_next = reload_next;
                    mode_next  = i_Mode;
                end
            end
            RUN: begin
                if (tick) begin
                    if (count != '0) begin
                        count_next = count - WIDTH'(1);
                    end else begin
                        expiry = 1'b1;
                        if (mode == MODE_ONESHOT) state_next = IDLE;
                        else                      count_next = reload_next;
                    end
                end
                // The tick is resolved first; a one-shot expiry wins over a pause.
                if (i_Stop && state_next == RUN) state_next = HOLD;
            end
            HOLD: begin
                if (i_Start && !i_Stop) state_next = RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_CLK or negedge i_RESET_n) begin
        if (!i_RESET_n) begin
            o_Busy    <= 1'b0;
            o_Expired <= 1'b0;
            o_Irq     <= 1'b0;
            o_Overrun <= 1'b0;
        end else begin
            o_Busy    <= (state_next != IDLE);
            o_Expired <= expiry;
            if (expiry) begin
                o_Irq <= 1'b1;
                if (o_Irq && !i_Irq_Ack) o_Overrun <= 1'b1;
            end else if (i_Irq_Ack) begin
                o_Irq     <= 1'b0;
                o_Overrun <= 1'b0;
            end
        end
    end

    assign o_Count = count;

endmodule

// File: doc/timer_controller.md
Name: timer_controller

Overview:
- Programmable interval timer controller sequencing a mod-PRESCALE tick prescaler and a down-counting period register.
- Sits on the Hack peripheral bus beside the UART/VGA blocks.
- CPU loads a reload value, selects one-shot or periodic mode, starts/stops/resumes the timer, and services a sticky interrupt with ack and overrun detection.

Parameters:
- PRESCALE, 16, clock cycles per timer tick (must be ≥ 2)
- WIDTH, 16, width of reload and count registers

Ports:
- i_CLK  input  1  system clock
- i_RESET_n  input  1  asynchronous, active-low reset
- i_Load  input  1  one-cycle strobe: capture i_Load_Value into the reload register
- i_Load_Value  input  WIDTH  reload value N; period = (N+1)*PRESCALE cycles
- i_Mode  input  1  sampled on Start: 0 one-shot, 1 periodic
- i_Start  input  1  strobe: start from IDLE or resume from HOLD
- i_Stop  input  1  strobe: pause a running timer
- i_Irq_Ack  input  1  strobe: clear o_Irq and o_Overrun
- o_Busy  output  1  high in RUN or HOLD
- o_Expired  output  1  one-cycle pulse on expiry
- o_Irq  output  1  sticky interrupt, set on expiry
- o_Overrun  output  1  sticky; expiry occurred while o_Irq already set
- o_Count  output  WIDTH  current down-count value

Behaviour:
- Single clock domain: i_CLK. Reset: asynchronous, active-low on i_RESET_n; on assertion, immediately and regardless of state:
  - state=IDLE; reload=0; count=0; mode=0; prescaler=0
  - all outputs 0
- Reset mid-operation abandons the run; no expiry is generated.
- States:
  - IDLE: prescaler cleared and frozen.
    - Start → RUN: count ← reload; mode latched; prescaler cleared to 0.
  - RUN: prescaler free-runs 0..PRESCALE-1; tick asserted combinationally when prescaler = PRESCALE-1.
    - On a tick with count>0: count ← count-1.
    - On a tick with count=0 (expiry): o_Expired=1 for the following cycle; o_Irq ← 1.
      - Periodic: count ← reload, stay RUN.
      - One-shot: → IDLE, count stays 0.
    - Stop → HOLD.
    - Start is ignored.
  - HOLD: count and prescaler frozen.
    - Start → RUN, resuming with the same prescaler phase.
    - Stop is ignored.
- Priority in one cycle: Stop beats Start. Stop in the same cycle as a tick: the tick is processed first (decrement/expiry), then → HOLD. If that tick is a one-shot expiry, the result is IDLE.
- Load:
  - Always updates reload.
  - In IDLE it also sets count ← i_Load_Value.
  - In RUN/HOLD, count is untouched; the new value takes effect at the next periodic reload.
  - Load and Start in the same cycle from IDLE: the new value is used.
- Timing: with Start sampled at edge E0 from IDLE and reload N, o_Expired is high during the cycle following edge E0+(N+1)*PRESCALE. o_Busy falls at that same edge in one-shot mode.
- N=0 gives a period of PRESCALE cycles. Count wraps only via reload, never below 0.
- Irq:
  - Set on expiry, cleared by Ack.
  - Expiry and Ack in the same cycle: o_Irq stays 1, and o_Overrun is unchanged.
  - Expiry while o_Irq=1 and no Ack: o_Overrun ← 1.
  - Ack clears o_Overrun.
- All outputs are registered, except that o_Count is driven directly from the count register.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, HOLD=2'd2)
  - mode constants (MODE_ONESHOT=0, MODE_PERIODIC=1)
- One sub-module, timer_prescaler:
  - mod-PRESCALE counter with synchronous clear and enable
  - async active-low reset
  - combinational tick output at PRESCALE-1
- The controller FSM, count register and Irq logic live in timer_controller.

Test Plan:
- PRESCALE=4, WIDTH=8 for all scenarios.
- One-shot: Load 3, Start with Mode=0 → o_Expired high exactly at cycle 16 after the Start edge; o_Busy 0 from that edge; o_Irq=1; o_Count=0.
- Periodic: Load 1, Mode=1, Start → o_Expired pulses at cycles 8, 16, 24; o_Count sequence 1,0,1,0…; o_Overrun=1 after the second pulse with no Ack.
- Pause: Load 3, one-shot, Start; Stop at cycle 5; hold 10 cycles; Start → expiry at cycle 16+10+1 (one cycle for the resume strobe); o_Count frozen at 2 during HOLD.
- Irq race: periodic with N=0; Ack coincident with the expiry edge → o_Irq stays 1, o_Overrun stays 0; next Ack alone → both 0.
- Priority/Load: Start+Stop in the same cycle from RUN → HOLD. Load 7 during RUN with reload 1 → current period finishes at 8 cycles, next period lasts 32.
- Reset: assert i_RESET_n=0 mid-RUN at count=2 → all outputs 0 asynchronously; after release, state IDLE and no spurious o_Expired for 40 cycles.
